lsu_store_buffer: RTL and testbench

- Load/store front-end sitting directly upstream of the data memory, between the EX/MEM pipeline stage and the memory port.
- Checks access alignment and funct3 legality, and posts stores into an in-order store buffer that drains to memory one entry per idle port cycle.
- Issues loads to the same single memory port with priority over draining.
- Detects read-after-write hazards against buffered stores.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/sb_fifo.sv | 68 ++++++
 rtl/lsu_store_buffer.sv | 135 +++++++++++++
 tb/tb_lsu_store_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU store buffer.
// Holds the funct3 encodings, the buffer entry layout and the legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [31:0]          wdata;
        logic [2:0]           funct3;
    } sb_entry_t;

    function automatic logic is_legal(
        input logic       write,
        input logic [2:0] funct3,
        input logic [1:0] lsb
    );
        logic ok;
        ok = 1'b0;
        unique case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lsb[0];
            F3_W:    ok = (lsb == 2'b00);
            F3_BU:   ok = ~write;
            F3_HU:   ok = ~write & ~lsb[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order circular store buffer with per-entry word-address match.
// Reports which live entries hit a given word and the youngest such hit.
module sb_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  sb_entry_t                 push_entry,
    input  logic [SB_ADDR_W-1:0]      match_addr,
    output sb_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]    count,
    output logic [DEPTH-1:0]          match,
    output logic [$clog2(DEPTH)-1:0]  youngest,
    output sb_entry_t                 youngest_entry
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        slots [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[tail] <= push_entry;
    end

    // Walk oldest to youngest so the last hit is the youngest match.
    always_comb begin
        logic [PW-1:0] idx;
        match    = '0;
        youngest = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count &&
                slots[idx].addr[SB_ADDR_W-1:2] ==
                match_addr[SB_ADDR_W-1:2]) begin
                match[idx] = 1'b1;
                youngest   = idx;
            end
        end
    end

    assign head_entry     = slots[head];
    assign youngest_entry = slots[youngest];

endmodule

// File: rtl/lsu_store_buffer.sv
// LSU front-end: legality, store buffering, load issue and drain arbitration.
// Define LSU_STORE_FWD_EN to forward SW data to a matching LW instead of stalling.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              buf_empty,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                 legal;
    logic                 hazard;
    logic                 fwd;
    logic                 full;
    logic                 empty;
    logic                 load_issue;
    logic                 load_take;
    logic                 push;
    logic                 drain;
    logic                 bad;
    logic [CW-1:0]        count;
    logic [DEPTH-1:0]     match;
    logic [PW-1:0]        youngest;
    logic [SB_ADDR_W-1:0] addr_w;
    sb_entry_t            push_entry;
    sb_entry_t            head_entry;
    sb_entry_t            youngest_entry;
    logic                 unused_sink;

    assign addr_w     = SB_ADDR_W'(req_addr);
    assign push_entry = '{addr: addr_w, wdata: req_wdata, funct3: req_funct3};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .pop            (drain),
        .push_entry     (push_entry),
        .match_addr     (addr_w),
        .head_entry     (head_entry),
        .count          (count),
        .match          (match),
        .youngest       (youngest),
        .youngest_entry (youngest_entry)
    );

    assign unused_sink = ^{youngest, youngest_entry.addr};

    assign legal  = is_legal(req_write, req_funct3, req_addr[1:0]);
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign hazard = |match;

`ifdef LSU_STORE_FWD_EN
    assign fwd = hazard && req_funct3 == F3_W
                 && youngest_entry.funct3 == F3_W;
`else
    assign fwd = 1'b0;
`endif

    always_comb begin
        req_ready      = 1'b0;
        load_issue     = 1'b0;
        load_take      = 1'b0;
        push           = 1'b0;
        bad            = 1'b0;
        drain          = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_funct3     = '0;
        if (!rst) begin
            if (!legal)         req_ready = 1'b1;
            else if (req_write) req_ready = !full;
            else                req_ready = !hazard || fwd;
            load_issue = req_valid && legal && !req_write && !hazard;
            load_take  = req_valid && legal && !req_write && fwd;
            push       = req_valid && legal && req_write && !full;
            bad        = req_valid && !legal;
            // A forwarded or stalled load leaves the port free for the drain.
            drain      = !empty && !load_issue;
            if (load_issue) begin
                mem_read    = 1'b1;
                mem_address = 32'(req_addr);
                mem_funct3  = req_funct3;
            end else if (drain) begin
                mem_write      = 1'b1;
                mem_address    = 32'(head_entry.addr);
                mem_write_data = head_entry.wdata;
                mem_funct3     = head_entry.funct3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_valid <= 1'b0;
            load_data  <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            load_valid <= load_issue || load_take;
            if (load_issue)     load_data <= mem_read_data;
            else if (load_take) load_data <= youngest_entry.wdata;
            fault <= bad;
            if (bad) fault_addr <= req_addr;
        end
    end

    assign buf_empty = empty;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed steps plus random traffic vs a queue model.
// Honours LSU_STORE_FWD_EN in the same way as the design.
module tb_lsu_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        load_valid;
    logic [31:0] load_data;
    logic        fault;
    logic [31:0] fault_addr;
    logic        buf_empty;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    lsu_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_funct3     (req_funct3),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .fault          (fault),
        .fault_addr     (fault_addr),
        .buf_empty      (buf_empty),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_funct3     (mem_funct3),
        .mem_read_data  (mem_read_data)
    );

    logic [7:0] env_mem [64];
    logic [7:0] ref_mem [64];

    function automatic int fsize(input logic [2:0] f);
        if (f[1]) return 4;
        if (f[0]) return 2;
        return 1;
    endfunction

    // Memory formats the load result itself from address and funct3.
    function automatic logic [31:0] mread(
        input logic [7:0]  m [64],
        input logic [31:0] a,
        input logic [2:0]  f
    );
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < fsize(f); i++)
            v = v | (32'(m[6'(a + 32'(i))]) << (8 * i));
        if (f == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    assign mem_read_data = mread(env_mem, mem_address, mem_funct3);

    function automatic bit legal_m(
        input bit w, input logic [2:0] f, input logic [31:0] a
    );
        if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (w && f > 3'd2) return 0;
        return (a % 32'(fsize(f))) == 0;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } st_t;

    st_t q[$];

    logic        c_v, c_w;
    logic [31:0] c_a, c_d;
    logic [2:0]  c_f;
    bit          m_lg, m_hz, m_fw, m_port, m_dr;
    int          m_yi;
    logic        e_rdy, e_rd, e_wr;
    logic [31:0] e_ad, e_wd;
    logic [2:0]  e_f3;
    logic        e_lv, e_flt;
    logic [31:0] e_ld, e_fa;
    logic        p_we;
    logic [31:0] p_ad, p_wd;
    logic [2:0]  p_f3;

    task automatic chk(
        input string tag, input logic [31:0] obs, input logic [31:0] exp
    );
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_comb();
        m_lg = legal_m(c_w, c_f, c_a);
        m_hz = 0;
        m_yi = 0;
        foreach (q[i]) begin
            if ((q[i].a >> 2) == (c_a >> 2)) begin
                m_hz = 1;
                m_yi = i;
            end
        end
        m_fw = 0;
`ifdef LSU_STORE_FWD_EN
        m_fw = m_hz && c_f == 3'd2 && q[m_yi].f == 3'd2;
`endif
        if (!m_lg)    e_rdy = 1;
        else if (c_w) e_rdy = q.size() < DEPTH;
        else          e_rdy = !m_hz || m_fw;
        m_port = c_v && m_lg && !c_w && !m_hz;
        m_dr   = q.size() > 0 && !m_port;
        e_rd = m_port;
        e_wr = !m_port && m_dr;
        e_ad = 0; e_wd = 0; e_f3 = 0;
        if (m_port) begin
            e_ad = c_a; e_f3 = c_f;
        end else if (m_dr) begin
            e_ad = q[0].a; e_wd = q[0].d; e_f3 = q[0].f;
        end
    endtask

    task automatic drive(
        input logic v, input logic w, input logic [31:0] a,
        input logic [31:0] d, input logic [2:0] f
    );
        c_v = v; c_w = w; c_a = a; c_d = d; c_f = f;
        req_valid = v; req_write = w; req_addr = a;
        req_wdata = d; req_funct3 = f;
        #1;
        model_comb();
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("mem_read", 32'(mem_read), 32'(e_rd));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("mem_address", mem_address, e_ad);
        chk("mem_wdata", mem_write_data, e_wd);
        chk("mem_funct3", 32'(mem_funct3), 32'(e_f3));
        chk("load_valid", 32'(load_valid), 32'(e_lv));
        chk("load_data", load_data, e_ld);
        chk("fault", 32'(fault), 32'(e_flt));
        chk("fault_addr", fault_addr, e_fa);
        chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
    endtask

    task automatic tick();
        bit take, pushm;
        st_t s;
        p_we = mem_write; p_ad = mem_address;
        p_wd = mem_write_data; p_f3 = mem_funct3;
        take  = c_v && m_lg && !c_w && e_rdy;
        pushm = c_v && m_lg && c_w && q.size() < DEPTH;
        e_lv  = take;
        if (take) e_ld = m_fw ? q[m_yi].d : mread(ref_mem, c_a, c_f);
        e_flt = c_v && !m_lg;
        if (e_flt) e_fa = c_a;
        if (m_dr) begin
            s = q.pop_front();
            for (int i = 0; i < fsize(s.f); i++)
                ref_mem[6'(s.a + 32'(i))] = s.d[8*i +: 8];
        end
        if (pushm) q.push_back('{a: c_a, d: c_d, f: c_f});
        @(posedge clk);
        if (p_we)
            for (int i = 0; i < fsize(p_f3); i++)
                env_mem[6'(p_ad + 32'(i))] = p_wd[8*i +: 8];
        @(negedge clk);
    endtask

    task automatic step(
        input logic v, input logic w, input logic [31:0] a,
        input logic [31:0] d, input logic [2:0] f
    );
        drive(v, w, a, d, f);
        tick();
    endtask

    task automatic model_reset();
        q.delete();
        e_lv = 0; e_ld = 0; e_flt = 0; e_fa = 0;
    endtask

    initial begin
        logic [2:0] ftab [5];
        logic [2:0] f;
        logic [31:0] a;
        ftab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        model_reset();
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0;
        req_wdata = 0; req_funct3 = 0;
        #1;
        chk("rst_load_valid", 32'(load_valid), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_buf_empty", 32'(buf_empty), 32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single store drains on the following idle cycle.
        drive(1, 1, 32'h10, 32'hDEAD_BEEF, 3'd2);
        chk("sw_ready", 32'(req_ready), 32'd1);
        tick();
        drive(0, 0, 32'h0, 32'h0, 3'd0);
        chk("sw_drain_we", 32'(mem_write), 32'd1);
        chk("sw_drain_ad", mem_address, 32'h10);
        chk("sw_drain_wd", mem_write_data, 32'hDEAD_BEEF);
        tick();
        drive(0, 0, 32'h0, 32'h0, 3'd0);
        chk("sw_empty", 32'(buf_empty), 32'd1);
        tick();

        // Store then load of the same word.
        step(1, 1, 32'h20, 32'h1234_5678, 3'd2);
        drive(1, 0, 32'h20, 32'h0, 3'd2);
`ifdef LSU_STORE_FWD_EN
        chk("raw_fwd_ready", 32'(req_ready), 32'd1);
        tick();
`else
        chk("raw_stall", 32'(req_ready), 32'd0);
        tick();
        drive(1, 0, 32'h20, 32'h0, 3'd2);
        chk("raw_retry", 32'(req_ready), 32'd1);
        tick();
`endif
        drive(0, 0, 32'h0, 32'h0, 3'd0);
        chk("raw_lv", 32'(load_valid), 32'd1);
        chk("raw_ld", load_data, 32'h1234_5678);
        tick();

        // Byte store then signed and unsigned byte loads.
        step(1, 1, 32'h21, 32'h80, 3'd0);
        drive(1, 0, 32'h21, 32'h0, 3'd0);
        chk("lb_stall", 32'(req_ready), 32'd0);
        tick();
        step(1, 0, 32'h21, 32'h0, 3'd0);
        drive(1, 0, 32'h21, 32'h0, 3'd4);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        tick();
        drive(0, 0, 32'h0, 32'h0, 3'd0);
        chk("lbu_data", load_data, 32'h0000_0080);
        tick();

        // Illegal and misaligned requests.
        drive(1, 0, 32'h22, 32'h0, 3'd2);
        chk("flt_ready", 32'(req_ready), 32'd1);
        chk("flt_noread", 32'(mem_read), 32'd0);
        tick();
        drive(1, 1, 32'h13, 32'h55, 3'd1);
        chk("flt_lw", 32'(fault), 32'd1);
        chk("flt_lw_ad", fault_addr, 32'h22);
        tick();
        drive(1, 0, 32'h30, 32'h0, 3'd3);
        chk("flt_sh_ad", fault_addr, 32'h13);
        tick();
        drive(0, 0, 32'h0, 32'h0, 3'd0);
        chk("flt_f3_ad", fault_addr, 32'h30);
        chk("flt_nowrite", 32'(mem_write), 32'd0);
        tick();

        for (int n = 0; n < 600; n++) begin
            f = ($urandom_range(0, 4) != 0) ?
                ftab[$urandom_range(0, 4)] : 3'($urandom);
            a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0)
                a = a & ~((32'(fsize(f))) - 32'd1);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 a, $urandom, f);
        end

        // Asynchronous reset in the middle of a cycle.
        step(1, 1, 32'h8, 32'hA5A5_A5A5, 3'd2);
        drive(1, 1, 32'hC, 32'h1111_2222, 3'd2);
        #2 rst = 1'b1;
        req_valid = 1; req_write = 0; req_addr = 32'h4; req_funct3 = 3'd2;
        #1;
        chk("arst_read", 32'(mem_read), 32'd0);
        chk("arst_write", 32'(mem_write), 32'd0);
        chk("arst_addr", mem_address, 32'd0);
        chk("arst_lv", 32'(load_valid), 32'd0);
        chk("arst_ld", load_data, 32'd0);
        chk("arst_fault", 32'(fault), 32'd0);
        chk("arst_fa", fault_addr, 32'd0);
        chk("arst_empty", 32'(buf_empty), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) step(0, 0, 32'h0, 32'h0, 3'd0);
        step(1, 0, 32'h8, 32'h0, 3'd2);
        step(1, 0, 32'hC, 32'h0, 3'd2);
        drive(0, 0, 32'h0, 32'h0, 3'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
